// File: rtl/jtag_tap_multi_if.sv
// Interface bundling the JTAG pin side and the core-side user channel
// signals of jtag_tap_multi. The TAP uses the slave view; the driver of
// the pins and the core logic (or a testbench) uses the master view.
interface jtag_tap_multi_if #(
  parameter int IR_WIDTH      = 5,
  parameter int NUM_USER      = 4,
  parameter int USER_DR_WIDTH = 32
);
  logic                              tms;
  logic                              tdi;
  logic                              tdo;
  logic                              tdo_oe;
  logic [3:0]                        tap_state;
  logic [IR_WIDTH-1:0]               ir_out;
  logic [NUM_USER-1:0]               user_sel;
  logic [NUM_USER*USER_DR_WIDTH-1:0] user_capture;
  logic [USER_DR_WIDTH-1:0]          user_update;
  logic [NUM_USER-1:0]               user_update_vld;

  modport slave (
    input  tms, tdi, user_capture,
    output tdo, tdo_oe, tap_state, ir_out, user_sel, user_update, user_update_vld
  );

  modport master (
    output tms, tdi, user_capture,
    input  tdo, tdo_oe, tap_state, ir_out, user_sel, user_update, user_update_vld
  );
endinterface

// File: rtl/jtag_tap_multi.sv
// Parametrised IEEE 1149.1 TAP controller with a configurable-width IR,
// BYPASS and IDCODE registers, and NUM_USER user data-register channels,
// each with its own capture slice and update strobe into core logic.
module jtag_tap_multi #(
  parameter int          IR_WIDTH      = 5,
  parameter logic [31:0] IDCODE        = 32'h1DC0_0001,
  parameter int          NUM_USER      = 4,
  parameter int          USER_DR_WIDTH = 32,
  parameter int          USER_IR_BASE  = 8
) (
  input  logic             tck,
  input  logic             trst,
  jtag_tap_multi_if.slave  jtag
);

  localparam int IDX_W = (NUM_USER > 1) ? $clog2(NUM_USER) : 1;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e               state;
  tap_state_e               state_nxt;

  logic [IR_WIDTH-1:0]      ir_shift;
  logic [IR_WIDTH-1:0]      ir_latch;
  logic                     bypass_reg;
  logic [31:0]              idcode_reg;
  logic [USER_DR_WIDTH-1:0] user_sr [NUM_USER];
  logic [USER_DR_WIDTH-1:0] user_update_q;
  logic [NUM_USER-1:0]      user_vld_q;

  logic [NUM_USER-1:0]      user_sel_d;
  logic [IDX_W-1:0]         user_idx;
  logic                     sel_idcode;
  logic                     sel_user;
  logic                     tdo_d;

  // Right shift with tdi entering at the MSB, usable for a 1-bit user DR.
  function automatic logic [USER_DR_WIDTH-1:0] user_shift(
    input logic [USER_DR_WIDTH-1:0] value,
    input logic                     bit_in
  );
    logic [USER_DR_WIDTH-1:0] res;
    res = value >> 1;
    res[USER_DR_WIDTH-1] = bit_in;
    return res;
  endfunction

  // TAP controller next-state table driven by tms.
  always_comb begin
    state_nxt = TLR;
    case (state)
      TLR:     state_nxt = jtag.tms ? TLR    : RTI;
      RTI:     state_nxt = jtag.tms ? SEL_DR : RTI;
      SEL_DR:  state_nxt = jtag.tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = jtag.tms ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = jtag.tms ? UPD_DR : PA_DR;
      PA_DR:   state_nxt = jtag.tms ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = jtag.tms ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = jtag.tms ? SEL_DR : RTI;
      SEL_IR:  state_nxt = jtag.tms ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = jtag.tms ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = jtag.tms ? UPD_IR : PA_IR;
      PA_IR:   state_nxt = jtag.tms ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = jtag.tms ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = jtag.tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // State register; trst forces Test-Logic-Reset regardless of tms.
  always_ff @(posedge tck) begin
    if (trst) state <= TLR;
    else      state <= state_nxt;
  end

  // Decode the latched instruction; unknown opcodes fall through to BYPASS.
  always_comb begin
    user_sel_d = '0;
    user_idx   = '0;
    sel_idcode = 1'b0;
    if (!(&ir_latch)) begin
      if (ir_latch == IR_WIDTH'(1)) begin
        sel_idcode = 1'b1;
      end else begin
        for (int k = 0; k < NUM_USER; k++) begin
          if ((USER_IR_BASE + k) < (1 << IR_WIDTH) &&
              ir_latch == IR_WIDTH'(USER_IR_BASE + k)) begin
            user_sel_d[k] = 1'b1;
            user_idx      = IDX_W'(k);
          end
        end
      end
    end
  end

  assign sel_user = |user_sel_d;

  // Instruction register: capture 01 pattern, shift, and latch on Update-IR.
  always_ff @(posedge tck) begin
    if (trst) begin
      ir_shift <= '0;
      ir_latch <= IR_WIDTH'(1);
    end else begin
      case (state)
        TLR:     ir_latch <= IR_WIDTH'(1);
        CAP_IR:  ir_shift <= IR_WIDTH'(1);
        SH_IR:   ir_shift <= {jtag.tdi, ir_shift[IR_WIDTH-1:1]};
        UPD_IR:  ir_latch <= ir_shift;
        default: ir_shift <= ir_shift;
      endcase
    end
  end

  // Data registers: only the register picked by the latched IR captures or shifts.
  always_ff @(posedge tck) begin
    if (trst) begin
      bypass_reg <= 1'b0;
      idcode_reg <= '0;
      for (int k = 0; k < NUM_USER; k++) user_sr[k] <= '0;
    end else if (state == CAP_DR) begin
      if (sel_user) begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (user_sel_d[k])
            user_sr[k] <= jtag.user_capture[k*USER_DR_WIDTH +: USER_DR_WIDTH];
        end
      end else if (sel_idcode) begin
        idcode_reg <= IDCODE;
      end else begin
        bypass_reg <= 1'b0;
      end
    end else if (state == SH_DR) begin
      if (sel_user) begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (user_sel_d[k]) user_sr[k] <= user_shift(user_sr[k], jtag.tdi);
        end
      end else if (sel_idcode) begin
        idcode_reg <= {jtag.tdi, idcode_reg[31:1]};
      end else begin
        bypass_reg <= jtag.tdi;
      end
    end
  end

  // Update-DR of a user channel hands the shifted word to the core with a one-cycle strobe.
  always_ff @(posedge tck) begin
    if (trst) begin
      user_update_q <= '0;
      user_vld_q    <= '0;
    end else begin
      user_vld_q <= '0;
      if (state == UPD_DR && sel_user) begin
        user_update_q <= user_sr[user_idx];
        user_vld_q    <= user_sel_d;
      end
    end
  end

  // tdo is the LSB of whichever register is being shifted, otherwise low.
  always_comb begin
    tdo_d = 1'b0;
    if (state == SH_IR) begin
      tdo_d = ir_shift[0];
    end else if (state == SH_DR) begin
      if (sel_user)        tdo_d = user_sr[user_idx][0];
      else if (sel_idcode) tdo_d = idcode_reg[0];
      else                 tdo_d = bypass_reg;
    end
  end

  assign jtag.tdo             = tdo_d;
  assign jtag.tdo_oe          = (state == SH_IR) || (state == SH_DR);
  assign jtag.tap_state       = state;
  assign jtag.ir_out          = ir_latch;
  assign jtag.user_sel        = user_sel_d;
  assign jtag.user_update     = user_update_q;
  assign jtag.user_update_vld = user_vld_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Directed testbench for jtag_tap_multi: expected tdo bits are queued when a
// scan is launched and popped as the DUT shifts them out.
module tb_jtag_tap_multi;

  localparam int IR_WIDTH      = 5;
  localparam int NUM_USER      = 4;
  localparam int USER_DR_WIDTH = 32;

  logic tck;
  logic trst;
  int   vectors;
  int   miscompares;
  logic sb_q[$];

  jtag_tap_multi_if #(
    .IR_WIDTH(IR_WIDTH), .NUM_USER(NUM_USER), .USER_DR_WIDTH(USER_DR_WIDTH)
  ) bus ();

  jtag_tap_multi #(
    .IR_WIDTH(IR_WIDTH), .IDCODE(32'h1DC0_0001), .NUM_USER(NUM_USER),
    .USER_DR_WIDTH(USER_DR_WIDTH), .USER_IR_BASE(8)
  ) dut (
    .tck(tck),
    .trst(trst),
    .jtag(bus)
  );

  // Free-running test clock.
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic tms_v, input logic tdi_v);
    bus.tms = tms_v;
    bus.tdi = tdi_v;
    @(posedge tck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // IR scan from Run-Test/Idle back to Run-Test/Idle, checking the 01 capture pattern.
  task automatic shiftIr(input logic [IR_WIDTH-1:0] value);
    logic exp_bit;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < IR_WIDTH; i++) sb_q.push_back(i == 0);
    for (int i = 0; i < IR_WIDTH; i++) begin
      exp_bit = sb_q.pop_front();
      checkOutput("tdo_ir", 32'(bus.tdo), 32'(exp_bit));
      applyStimulus(i == IR_WIDTH - 1, value[i]);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ir_out", 32'(bus.ir_out), 32'(value));
  endtask

  // DR scan of n bits from Run-Test/Idle to Run-Test/Idle, optionally pausing after bit pause_at.
  task automatic scanDr(input int n, input logic [31:0] data,
                        input logic [31:0] exp_tdo, input int pause_at);
    logic exp_bit;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tdo_oe_shift", 32'(bus.tdo_oe), 32'd1);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_tdo[i]);
    for (int i = 0; i < n; i++) begin
      exp_bit = sb_q.pop_front();
      checkOutput("tdo_dr", 32'(bus.tdo), 32'(exp_bit));
      if (i == pause_at && i != n - 1) begin
        applyStimulus(1'b1, data[i]);
        applyStimulus(1'b0, 1'b0);
        for (int p = 0; p < 10; p++) applyStimulus(1'b0, 1'b0);
        checkOutput("pause_state", 32'(bus.tap_state), 32'd6);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
      end else begin
        applyStimulus(i == n - 1, data[i]);
      end
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("tdo_oe_idle", 32'(bus.tdo_oe), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    trst        = 1'b1;
    bus.tms     = 1'b0;
    bus.tdi     = 1'b0;
    bus.user_capture = {32'hFEED_FACE, 32'h0BAD_C0DE, 32'hCAFE_F00D, 32'hDEAD_BEEF};

    // Reset, then walk to Run-Test/Idle and read IDCODE.
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_state", 32'(bus.tap_state), 32'd0);
    checkOutput("rst_ir", 32'(bus.ir_out), 32'd1);
    checkOutput("rst_tdo_oe", 32'(bus.tdo_oe), 32'd0);
    checkOutput("rst_update", bus.user_update, 32'd0);
    checkOutput("rst_vld", 32'(bus.user_update_vld), 32'd0);
    trst = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("tlr_hold", 32'(bus.tap_state), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rti_state", 32'(bus.tap_state), 32'd1);
    checkOutput("rti_ir", 32'(bus.ir_out), 32'd1);
    scanDr(32, 32'h0, 32'h1DC0_0001, -1);

    // BYPASS: one-cycle delay through the bypass flop.
    shiftIr(5'b11111);
    checkOutput("bypass_sel", 32'(bus.user_sel), 32'd0);
    scanDr(8, 32'h0000_00A5, 32'h0000_00A5 << 1, -1);
    checkOutput("bypass_novld", 32'(bus.user_update_vld), 32'd0);

    // USER0 capture/update.
    shiftIr(5'd8);
    checkOutput("user0_sel", 32'(bus.user_sel), 32'b0001);
    scanDr(32, 32'h1234_5678, 32'hDEAD_BEEF, -1);
    checkOutput("user0_update", bus.user_update, 32'h1234_5678);
    checkOutput("user0_vld", 32'(bus.user_update_vld), 32'b0001);
    applyStimulus(1'b0, 1'b0);
    checkOutput("user0_vld_clr", 32'(bus.user_update_vld), 32'd0);
    checkOutput("user0_hold", bus.user_update, 32'h1234_5678);

    // Decode edges: last user opcode and first opcode past the user range.
    shiftIr(5'd11);
    checkOutput("user3_sel", 32'(bus.user_sel), 32'b1000);
    shiftIr(5'd12);
    checkOutput("op12_sel", 32'(bus.user_sel), 32'd0);
    scanDr(4, 32'h0000_000B, 32'h0000_000B << 1, -1);
    checkOutput("op12_novld", 32'(bus.user_update_vld), 32'd0);
    checkOutput("op12_update", bus.user_update, 32'h1234_5678);

    // USER1 straight scan, then a scan paused mid-way.
    shiftIr(5'd9);
    checkOutput("user1_sel", 32'(bus.user_sel), 32'b0010);
    scanDr(32, 32'h0F0F_A5A5, 32'hCAFE_F00D, -1);
    checkOutput("user1_update", bus.user_update, 32'h0F0F_A5A5);
    checkOutput("user1_vld", 32'(bus.user_update_vld), 32'b0010);
    scanDr(32, 32'h3C3C_5A5A, 32'hCAFE_F00D, 13);
    checkOutput("user1p_update", bus.user_update, 32'h3C3C_5A5A);
    checkOutput("user1p_vld", 32'(bus.user_update_vld), 32'b0010);

    // Short USER1 scan: update still applies the partially shifted word.
    scanDr(4, 32'h0000_0009, 32'hCAFE_F00D, -1);
    checkOutput("short_update", bus.user_update, 32'h9CAF_EF00);
    checkOutput("short_vld", 32'(bus.user_update_vld), 32'b0010);

    // trst in the middle of a USER2 shift discards everything.
    shiftIr(5'd10);
    checkOutput("user2_sel", 32'(bus.user_sel), 32'b0100);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("user2_tdo0", 32'(bus.tdo), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1);
    trst = 1'b1;
    applyStimulus(1'b1, 1'b1);
    trst = 1'b0;
    checkOutput("mid_rst_state", 32'(bus.tap_state), 32'd0);
    checkOutput("mid_rst_ir", 32'(bus.ir_out), 32'd1);
    checkOutput("mid_rst_update", bus.user_update, 32'd0);
    checkOutput("mid_rst_vld", 32'(bus.user_update_vld), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_rst_state", 32'(bus.tap_state), 32'd1);
    checkOutput("post_rst_vld", 32'(bus.user_update_vld), 32'd0);

    // Five tms=1 from Shift-IR lands in Test-Logic-Reset.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("shir_state", 32'(bus.tap_state), 32'd11);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("five_ones", 32'(bus.tap_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
